// File: rtl/fifo_pkg.sv
// Shared constants and types for the RAM-backed FIFO controller.
package fifo_pkg;

    localparam int unsigned ADDR_WIDTH_DEF = 8;
    localparam int unsigned DATA_WIDTH_DEF = 8;

    // Pointer with one extra wrap bit so full and empty can be told apart
    typedef logic [ADDR_WIDTH_DEF:0] ptr_t;

endpackage

// File: rtl/RAM_assign.sv
// Simple dual-port RAM with registered read outputs on both ports.
module RAM_assign #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk_a,
    input  logic                  clk_b,
    input  logic [ADDR_WIDTH-1:0] add_a,
    input  logic [ADDR_WIDTH-1:0] add_b,
    input  logic [DATA_WIDTH-1:0] din_a,
    input  logic [DATA_WIDTH-1:0] din_b,
    input  logic                  we_a,
    input  logic                  we_b,
    output logic [DATA_WIDTH-1:0] dout_a,
    output logic [DATA_WIDTH-1:0] dout_b
);

    localparam int unsigned DEPTH = 2**ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Both write ports commit on clk_a; the ports share one clock in practice
    always_ff @(posedge clk_a) begin
        if (we_a) mem[add_a] <= din_a;
        if (we_b) mem[add_b] <= din_b;
        dout_a <= mem[add_a];
    end

    always_ff @(posedge clk_b) begin
        dout_b <= mem[add_b];
    end

endmodule

// File: rtl/fifo_ptr.sv
// Wrap-bit FIFO pointer: increments on enable, wraps modulo 2**WIDTH.
module fifo_ptr
    import fifo_pkg::*;
#(
    parameter int unsigned WIDTH = ADDR_WIDTH_DEF + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] ptr
);

    logic [WIDTH-1:0] ptr_d;
    logic [WIDTH-1:0] ptr_q;

    always_comb begin
        ptr_d = ptr_q;
        if (inc) ptr_d = ptr_q + WIDTH'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) ptr_q <= '0;
        else      ptr_q <= ptr_d;
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller around a dual-port RAM: port A writes, port B reads.
module ram_fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned AF_LEVEL   = 2**ADDR_WIDTH - 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_req,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_req,
    input  logic                  clr_err,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow,
    output logic [ADDR_WIDTH-1:0] ram_add_a,
    output logic [ADDR_WIDTH-1:0] ram_add_b,
    output logic [DATA_WIDTH-1:0] ram_din_a,
    output logic                  ram_we_a,
    output logic                  ram_we_b,
    output logic [DATA_WIDTH-1:0] ram_din_b,
    input  logic [DATA_WIDTH-1:0] ram_dout_b
);

    localparam int unsigned PW = ADDR_WIDTH + 1;

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          wr_acc;
    logic          rd_acc;

    logic [PW-1:0] count_d,     count_q;
    logic          rd_valid_d,  rd_valid_q;
    logic          overflow_d,  overflow_q;
    logic          underflow_d, underflow_q;

    fifo_ptr #(.WIDTH(PW)) u_wr_ptr (
        .clk (clk),
        .rst (rst),
        .inc (wr_acc),
        .ptr (wr_ptr)
    );

    fifo_ptr #(.WIDTH(PW)) u_rd_ptr (
        .clk (clk),
        .rst (rst),
        .inc (rd_acc),
        .ptr (rd_ptr)
    );

    // Status flags from the registered pointers and count
    assign empty       = (wr_ptr == rd_ptr);
    assign full        = (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]) &&
                         (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]);
    assign almost_full = (count_q >= PW'(AF_LEVEL));

    // A full FIFO rejects writes even if a read frees a slot the same cycle
    assign wr_acc = wr_req & ~full;
    assign rd_acc = rd_req & ~empty;

    always_comb begin
        count_d     = count_q;
        rd_valid_d  = rd_acc;
        overflow_d  = (wr_req & full)  | (overflow_q  & ~clr_err);
        underflow_d = (rd_req & empty) | (underflow_q & ~clr_err);
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + PW'(1);
            2'b01:   count_d = count_q - PW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q     <= '0;
            rd_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            rd_valid_q  <= rd_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign count     = count_q;
    assign rd_valid  = rd_valid_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

    // RAM port mapping; the write enable is held off while reset is asserted
    assign ram_we_a  = wr_acc & rst;
    assign ram_add_a = wr_ptr[ADDR_WIDTH-1:0];
    assign ram_din_a = wr_data;
    assign ram_add_b = rd_ptr[ADDR_WIDTH-1:0];
    assign ram_we_b  = 1'b0;
    assign ram_din_b = '0;
    assign rd_data   = ram_dout_b;

endmodule

// File: doc/ram_fifo_ctrl.md
# ram_fifo_ctrl

FIFO controller that drives the dual-port RAM (`RAM_assign`) and turns it into a first-in/first-out buffer. Port A is the write port and port B is the read port. The block owns the write/read pointers, occupancy count, full/empty/almost-full flags, read-data valid and sticky error flags. Producers write on the upstream side. Consumers take `rd_data` qualified by `rd_valid` on the downstream side.

## Interface
Parameters:
- `ADDR_WIDTH`, 8, RAM address width; FIFO depth DEPTH = 2**ADDR_WIDTH
- `DATA_WIDTH`, 8, data width
- `AF_LEVEL`, 2**ADDR_WIDTH-2, count at or above which `almost_full` asserts

Ports:
- `clk`  in  1  single clock; also drives RAM `clk_a` and `clk_b`
- `rst`  in  1  asynchronous, active-low reset
- `wr_req`  in  1  write request
- `wr_data`  in  DATA_WIDTH  write data
- `rd_req`  in  1  read request
- `clr_err`  in  1  synchronous clear of `overflow`/`underflow`
- `rd_data`  out  DATA_WIDTH  read data, valid when `rd_valid`
- `rd_valid`  out  1  one-cycle pulse per accepted read
- `full`, `empty`, `almost_full`  out  1  status flags
- `count`  out  ADDR_WIDTH+1  occupancy, 0..DEPTH
- `overflow`, `underflow`  out  1  sticky error flags
- `ram_add_a`, `ram_add_b`  out  ADDR_WIDTH  RAM addresses
- `ram_din_a`  out  DATA_WIDTH  RAM port A data
- `ram_we_a`, `ram_we_b`  out  1  RAM write enables; `ram_we_b` is tied 0
- `ram_din_b`  out  DATA_WIDTH  tied 0
- `ram_dout_b`  in  DATA_WIDTH  registered RAM port B output

## Operation
- Pointers: `wr_ptr` and `rd_ptr` are each ADDR_WIDTH+1 bits. The MSB is the wrap bit.
- Flags:
  - `empty` when the two pointers are equal.
  - `full` when the MSBs differ and the low bits are equal.
- Write acceptance: wr_acc = `wr_req` & ~`full`.
  - `ram_we_a` = wr_acc (combinational).
  - `ram_add_a` = `wr_ptr` low bits.
  - `ram_din_a` = `wr_data`.
- Read acceptance: rd_acc = `rd_req` & ~`empty`.
  - `ram_add_b` = `rd_ptr` low bits, driven continuously.
- Pointer updates on the `clk` edge: `wr_ptr` increments on wr_acc; `rd_ptr` increments on rd_acc. Both wrap modulo 2·DEPTH.
- Count: `count` is registered. It is +1 on wr_acc only, −1 on rd_acc only, and unchanged when both or neither occur.
- Flag sourcing: `full` and `empty` are derived from registered pointers. `almost_full` = (`count` >= AF_LEVEL).
- Simultaneous read and write:
  - When empty, only the write is accepted; there is no fall-through.
  - When full, only the read is accepted; the write is rejected even though a slot frees that cycle.
- Errors:
  - `overflow` sets on `wr_req` & `full`.
  - `underflow` sets on `rd_req` & `empty`.
  - Both hold until `clr_err` or reset. If a set condition and `clr_err` occur in the same cycle, set wins.
- No address collision: a read address never equals an active write address, because writes are blocked when full and reads are blocked when empty.
- `rd_data` = `ram_dout_b`, passed through combinationally.

## Timing
- Reset (asynchronous, `rst`=0):
  - Pointers and `count` go to 0.
  - `empty`=1; `full`=0, `almost_full`=0, `rd_valid`=0, `overflow`=0, `underflow`=0.
  - `ram_we_a`=0 whenever `rst`=0.
- Reset mid-operation: all stored contents are abandoned. The RAM array is not cleared.
- Write latency: data presented with wr_acc in cycle N is stored at edge N. It is readable from cycle N+1, when `empty` deasserts.
- Read latency: rd_acc in cycle N lets the RAM sample `ram_add_b` at edge N. `rd_valid`=1 with `rd_data` valid during cycle N+1 (a registered pulse).
- Back-to-back reads: a read every cycle gives `rd_valid` continuously high, one word per cycle.
- Flag updates: flags and `count` update at the same edge as the pointers.

## Structure
- Shared package `fifo_pkg` holds:
  - default ADDR_WIDTH/DATA_WIDTH constants;
  - a `ptr_t` typedef of ADDR_WIDTH+1 bits.
- One natural sub-module, `fifo_ptr`: a wrap-bit pointer with increment enable. It is instantiated twice (write and read).
- The flag/count/error logic and the RAM port mapping live in the top level.
- The bench instantiates `ram_fifo_ctrl` together with `RAM_assign`.

## Test plan
- Reset then idle:
  - stimulus: `rst` held low for 2 cycles, then released;
  - required: `empty`=1, `count`=0, `full`=0, `rd_valid`=0, `ram_we_a`=0.
- Write then read back:
  - stimulus: write 8 words with data = i·3 for i=0..7, then 8 consecutive reads;
  - required: `count` 8 after the writes; `rd_data` sequence 0,3,6,…,21, each on a `rd_valid` pulse one cycle after its request; `empty`=1 at the end.
- Fill to full:
  - stimulus: 256 writes, then a 257th write;
  - required: `almost_full` rises at `count`=254; `full` at 256; the 257th write sets `overflow` with `ram_we_a`=0 and `count` staying 256.
- Simultaneous read and write at mid-occupancy:
  - stimulus: `count`=5, then 10 cycles with both `wr_req` and `rd_req`;
  - required: `count` stays 5; output order is preserved.
- Pointer wrap:
  - stimulus: 300 interleaved write/read pairs;
  - required: data is intact across the 255→0 address wrap; `full` never asserts.
- Empty read and error clear:
  - stimulus: `rd_req` while `empty`, then `clr_err`, then async reset asserted mid-stream;
  - required: `underflow`=1 with no `rd_valid` pulse; `clr_err` clears the flag; the reset forces `count`=0 and `empty`=1 immediately, without waiting for a clock edge.
